serializer_multi: RTL and testbench

SERIALIZER_MULTI -- requirements
Module: serializer_multi

---
 rtl/serializer_multi_pkg.sv | 22 ++
 rtl/serializer_lane.sv | 45 ++++
 rtl/serializer_multi.sv | 168 ++++++++++++++++
 tb/tb_serializer_multi.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serializer_multi_pkg.sv
// rtl/serializer_multi_pkg.sv - shared state type and parameter limits for serializer_multi
package serializer_multi_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int NUM_CH_MIN  = 1;
  localparam int NUM_CH_MAX  = 8;
  localparam int WIDTH_MIN   = 2;
  localparam int WIDTH_MAX   = 32;
  localparam int CLK_DIV_MIN = 2;

  // True when the lane count, word width and divider are all legal.
  function automatic bit params_ok(input int num_ch, input int width, input int clk_div);
    return (num_ch >= NUM_CH_MIN) && (num_ch <= NUM_CH_MAX) &&
           (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
           (clk_div >= CLK_DIV_MIN) && ((clk_div % 2) == 0);
  endfunction

endpackage

// File: rtl/serializer_lane.sv
// rtl/serializer_lane.sv - one lane load/shift register, fills vacated bits with the idle level
module serializer_lane #(
  parameter int WIDTH       = 24,
  parameter bit MSB_FIRST   = 1'b1,
  parameter bit DEFAULT_VAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out
);

  localparam logic [WIDTH-1:0] FILL_WORD = {WIDTH{DEFAULT_VAL}};

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Load wins over shift; shifting pushes the idle level in behind the outgoing bit.
  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_data;
    end else if (shift) begin
      if (MSB_FIRST) begin
        sr_d = {sr_q[WIDTH-2:0], DEFAULT_VAL};
      end else begin
        sr_d = {DEFAULT_VAL, sr_q[WIDTH-1:1]};
      end
    end
  end

  // Shift register; reset leaves the lane at the idle level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q <= FILL_WORD;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign ser_out = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/serializer_multi.sv
// rtl/serializer_multi.sv - multi-lane framed serializer with shared sclk/fsync and a one-word hold buffer
module serializer_multi
  import serializer_multi_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int WIDTH       = 24,
  parameter int CLK_DIV     = 4,
  parameter bit MSB_FIRST   = 1'b1,
  parameter bit DEFAULT_VAL = 1'b1,
  parameter bit FREE_RUN    = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic                    sclk,
  output logic                    fsync,
  output logic [NUM_CH-1:0]       data_ser,
  output logic                    busy,
  output logic                    underrun
);

  if (!params_ok(NUM_CH, WIDTH, CLK_DIV)) begin : g_bad_params
    $error("serializer_multi: NUM_CH, WIDTH or CLK_DIV out of range");
  end

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] FILL_WORD = {WIDTH{DEFAULT_VAL}};

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [NUM_CH*WIDTH-1:0] hold_q, hold_d;
  logic                    hold_full_q, hold_full_d;
  logic                    ready_en_q, ready_en_d;
  logic                    sclk_q, sclk_d;
  logic                    fsync_q, fsync_d;
  logic                    underrun_q, underrun_d;

  logic load_now;
  logic load_fill;
  logic shift_en;
  logic accept;

  // Sequencer: divider, bit index and frame-boundary decisions (real word, fill frame or stop).
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    load_now   = 1'b0;
    load_fill  = 1'b0;
    shift_en   = 1'b0;
    underrun_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (hold_full_q) begin
          load_now = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
            if (hold_full_q) begin
              load_now = 1'b1;
            end else if (FREE_RUN) begin
              load_fill  = 1'b1;
              underrun_d = 1'b1;
            end else begin
              // Final shift empties the lanes to the idle level.
              shift_en = 1'b1;
              state_d  = ST_IDLE;
            end
          end else begin
            bit_d    = bit_q + 1'b1;
            shift_en = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign in_ready = ready_en_q && (!hold_full_q || load_now);
  assign accept   = in_valid && in_ready;

  // Hold register: a boundary drains it, an accept refills it in the same cycle.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    ready_en_d  = 1'b1;
    if (load_now) begin
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end
  end

  // Registered sclk/fsync follow the next divider position so they line up with the data edge.
  always_comb begin
    sclk_d  = (state_d == ST_RUN) && (cnt_d >= CNT_HALF);
    fsync_d = (state_d == ST_RUN) && (bit_d == '0);
  end

  // State and control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ready_en_q  <= 1'b0;
      sclk_q      <= 1'b0;
      fsync_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ready_en_q  <= ready_en_d;
      sclk_q      <= sclk_d;
      fsync_q     <= fsync_d;
      underrun_q  <= underrun_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    logic [WIDTH-1:0] lane_word;
    assign lane_word = load_fill ? FILL_WORD : hold_q[k*WIDTH +: WIDTH];

    serializer_lane #(
      .WIDTH       (WIDTH),
      .MSB_FIRST   (MSB_FIRST),
      .DEFAULT_VAL (DEFAULT_VAL)
    ) u_lane (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (load_now || load_fill),
      .shift     (shift_en),
      .load_data (lane_word),
      .ser_out   (data_ser[k])
    );
  end

  assign sclk     = sclk_q;
  assign fsync    = fsync_q;
  assign busy     = (state_q == ST_RUN);
  assign underrun = underrun_q;

endmodule

// File: tb/tb_serializer_multi.sv
// tb/tb_serializer_multi.sv - randomized self-checking bench for serializer_multi (three parameter sets)
module tb_serializer_multi;

  localparam int W   = 8;
  localparam int NCH = 2;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid [3];
  logic [15:0] in_data  [3];
  logic        in_ready_w [3];
  logic        sclk_w     [3];
  logic        fsync_w    [3];
  logic        busy_w     [3];
  logic        underrun_w [3];
  logic [1:0]  data_w     [3];

  int checks   = 0;
  int failures = 0;

  logic [3:0]  cap [3][$];
  logic [15:0] acc [3][$];
  int   busy_cyc   [3] = '{0, 0, 0};
  int   frames_tot [3] = '{0, 0, 0};
  int   rdy_bad    [3] = '{0, 0, 0};
  int   ur_wide    [3] = '{0, 0, 0};
  int   nfill      [3] = '{0, 0, 0};
  logic ur_pend    [3] = '{1'b0, 1'b0, 1'b0};
  logic sclk_prev  [3] = '{1'b0, 1'b0, 1'b0};
  logic ur_prev    [3] = '{1'b0, 1'b0, 1'b0};
  logic b_started  = 1'b0;
  int   b_drop     = 0;

  always #5 clk = ~clk;

  serializer_multi #(.NUM_CH(NCH), .WIDTH(W), .CLK_DIV(DIV), .MSB_FIRST(1'b1),
                     .DEFAULT_VAL(1'b1), .FREE_RUN(1'b0)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[0]), .in_ready(in_ready_w[0]),
    .in_data(in_data[0]), .sclk(sclk_w[0]), .fsync(fsync_w[0]), .data_ser(data_w[0]),
    .busy(busy_w[0]), .underrun(underrun_w[0]));

  serializer_multi #(.NUM_CH(NCH), .WIDTH(W), .CLK_DIV(DIV), .MSB_FIRST(1'b1),
                     .DEFAULT_VAL(1'b1), .FREE_RUN(1'b1)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[1]), .in_ready(in_ready_w[1]),
    .in_data(in_data[1]), .sclk(sclk_w[1]), .fsync(fsync_w[1]), .data_ser(data_w[1]),
    .busy(busy_w[1]), .underrun(underrun_w[1]));

  serializer_multi #(.NUM_CH(NCH), .WIDTH(W), .CLK_DIV(DIV), .MSB_FIRST(1'b0),
                     .DEFAULT_VAL(1'b0), .FREE_RUN(1'b0)) u_dut_c (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid[2]), .in_ready(in_ready_w[2]),
    .in_data(in_data[2]), .sclk(sclk_w[2]), .fsync(fsync_w[2]), .data_ser(data_w[2]),
    .busy(busy_w[2]), .underrun(underrun_w[2]));

  function automatic bit msb_of(input int d);
    return d != 2;
  endfunction

  function automatic bit def_of(input int d);
    return d != 2;
  endfunction

  function automatic bit free_of(input int d);
    return d == 1;
  endfunction

  // Expected frame as seen at successive sclk rises: entry i = {fsync, lane1 bit, lane0 bit}.
  function automatic logic [23:0] exp_frame(input logic [15:0] w, input bit msb);
    logic [23:0] f;
    f = '0;
    for (int i = 0; i < W; i++) begin
      int b;
      b = msb ? (W - 1 - i) : i;
      f[i*3 +: 3] = {(i == 0), w[W + b], w[b]};
    end
    return f;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Observer: accepted words, sclk-rise samples, underrun/busy/ready bookkeeping.
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (reset_n) begin
          if (in_valid[d] && in_ready_w[d]) begin
            acc[d].push_back(in_data[d]);
            frames_tot[d]++;
          end
          if (underrun_w[d]) begin
            if (ur_prev[d]) ur_wide[d]++;
            ur_pend[d] = 1'b1;
          end
          if (sclk_w[d] && !sclk_prev[d]) begin
            cap[d].push_back({ur_pend[d], fsync_w[d], data_w[d]});
            ur_pend[d] = 1'b0;
          end
          if (busy_w[d]) busy_cyc[d]++;
          if (!in_ready_w[d] && !busy_w[d]) rdy_bad[d]++;
        end
        sclk_prev[d] = sclk_w[d];
        ur_prev[d]   = underrun_w[d];
      end
      if (busy_w[1]) b_started = 1'b1;
      else if (b_started && reset_n) b_drop++;
    end
  end

  // Called just after a rising edge; returns just after the edge that took the word.
  task automatic send(input int d, input logic [15:0] w);
    int t;
    in_valid[d] = 1'b1;
    in_data[d]  = w;
    t = 0;
    @(negedge clk);
    while (!in_ready_w[d] && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check_val($sformatf("d%0d_send_timeout", d), (t < 2000), 1);
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int d);
    int t;
    repeat (3) @(negedge clk);
    t = 0;
    while (busy_w[d] && t < 5000) begin
      @(negedge clk);
      t++;
    end
    check_val($sformatf("d%0d_idle_timeout", d), (t < 5000), 1);
    @(posedge clk);
    #1;
  endtask

  // Walk the captured bits frame by frame against the accepted-word queue.
  task automatic check_stream(input int d);
    int nfr;
    logic [23:0] got;
    logic [15:0] fill_w;
    logic [15:0] w;
    logic ur0;
    fill_w = def_of(d) ? 16'hFFFF : 16'h0000;
    nfr = cap[d].size() / W;
    if (!free_of(d)) begin
      check_val($sformatf("d%0d_bitcount", d), cap[d].size(), acc[d].size() * W);
    end
    for (int f = 0; f < nfr; f++) begin
      got = '0;
      ur0 = cap[d][f*W][3];
      for (int i = 0; i < W; i++) got[i*3 +: 3] = cap[d][f*W + i][2:0];
      if (free_of(d) && got == exp_frame(fill_w, msb_of(d))) begin
        check_val($sformatf("d%0d_fill_underrun", d), ur0, 1);
        nfill[d]++;
      end else if (acc[d].size() == 0) begin
        check_val($sformatf("d%0d_extra_frame", d), acc[d].size(), 1);
      end else begin
        w = acc[d].pop_front();
        check_val($sformatf("d%0d_frame_%0h", d, w), got, exp_frame(w, msb_of(d)));
        check_val($sformatf("d%0d_no_underrun", d), ur0, 0);
      end
    end
    check_val($sformatf("d%0d_words_left", d), acc[d].size(), 0);
    cap[d].delete();
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w == 16'hFFFF || w == 16'h0000) w = 16'h1234;
    return w;
  endfunction

  initial begin
    int t;
    reset_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0;
      in_data[d]  = '0;
    end

    // Reset values
    repeat (2) @(posedge clk);
    #2;
    check_val("rst_sclk", sclk_w[0], 0);
    check_val("rst_fsync", fsync_w[0], 0);
    check_val("rst_busy", busy_w[0], 0);
    check_val("rst_underrun", underrun_w[1], 0);
    check_val("rst_in_ready", in_ready_w[0], 0);
    check_val("rst_data_a", data_w[0], 2'b11);
    check_val("rst_data_c", data_w[2], 2'b00);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    #1;
    check_val("rel_in_ready_pre_edge", in_ready_w[0], 0);
    @(posedge clk);
    #1;
    check_val("rel_in_ready_post_edge", in_ready_w[0], 1);

    // Single word from IDLE, first-bit latency
    send(0, 16'h5AC3);
    @(negedge clk);
    check_val("lat_busy_hold_cycle", busy_w[0], 0);
    @(negedge clk);
    check_val("lat_busy_start", busy_w[0], 1);
    check_val("lat_fsync_start", fsync_w[0], 1);
    check_val("lat_sclk_start", sclk_w[0], 0);
    check_val("lat_first_bits", data_w[0], 2'b01);
    wait_idle(0);
    check_val("a_idle_data", data_w[0], 2'b11);
    check_val("a_idle_fsync", fsync_w[0], 0);
    check_val("a_idle_sclk", sclk_w[0], 0);
    check_stream(0);

    // Back-to-back with in_valid held, then random gaps
    for (int i = 0; i < 3; i++) send(0, rand_word());
    for (int i = 0; i < 10; i++) begin
      idle_cycles(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 70)) : 0);
      send(0, rand_word());
    end
    wait_idle(0);
    check_stream(0);
    check_val("a_no_gap_busy_cycles", busy_cyc[0], frames_tot[0] * W * DIV);

    // Free-running lanes: one word then starvation, then random traffic
    send(1, rand_word());
    idle_cycles(3 * W * DIV + 10);
    for (int i = 0; i < 6; i++) begin
      idle_cycles(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 80)) : 0);
      send(1, rand_word());
    end
    idle_cycles(3 * W * DIV);
    check_stream(1);
    check_val("b_fill_frames_seen", (nfill[1] >= 2), 1);
    check_val("b_busy_never_drops", b_drop, 0);
    check_val("b_underrun_single_clk", ur_wide[1], 0);

    // LSB-first lanes idling low
    send(2, {8'($urandom), 8'h01});
    wait_idle(2);
    check_val("c_idle_data", data_w[2], 2'b00);
    for (int i = 0; i < 6; i++) begin
      idle_cycles(($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 50)) : 0);
      send(2, rand_word());
    end
    wait_idle(2);
    check_stream(2);
    check_val("c_no_gap_busy_cycles", busy_cyc[2], frames_tot[2] * W * DIV);

    for (int d = 0; d < 3; d++) begin
      check_val($sformatf("d%0d_ready_low_while_idle", d), rdy_bad[d], 0);
    end

    // Reset during bit 3 of a frame
    send(0, rand_word());
    t = 0;
    @(posedge clk);
    while (cap[0].size() < 4 && t < 500) begin
      @(posedge clk);
      t++;
    end
    check_val("mid_reset_reach_bit3", (t < 500), 1);
    #3;
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_sclk", sclk_w[0], 0);
    check_val("mid_rst_fsync", fsync_w[0], 0);
    check_val("mid_rst_busy", busy_w[0], 0);
    check_val("mid_rst_data", data_w[0], 2'b11);
    check_val("mid_rst_in_ready", in_ready_w[0], 0);
    check_val("mid_rst_busy_b", busy_w[1], 0);
    check_val("mid_rst_underrun_b", underrun_w[1], 0);
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cap[0].delete();
    acc[0].delete();
    check_val("mid_rel_in_ready", in_ready_w[0], 1);
    send(0, 16'hA55A);
    wait_idle(0);
    check_stream(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
